// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//   Serial-to-parallel UART receiver. Default frame is 8N1 (8 data bits, LSB
//   first, one stop bit). Bit timing is generated locally from i_clk and every
//   bit is sampled at its middle. A good byte is delivered with a one-cycle
//   o_rx_valid pulse; a low stop bit gives a one-cycle o_frame_err pulse.
//
// Configuration macro:
//   UART_RX_PARITY_EN  defined   -> 8E1 frame, PARITY state inserted after the
//                                   data bits, o_parity_err reports mismatch
//                      undefined -> 8N1 frame, PARITY state unreachable,
//                                   o_parity_err tied low
//
// Parameters:
//   BIT_CYCLES    clk cycles per bit period (even, >= 4)
//
// Ports:
//   i_clk         system clock
//   i_reset       asynchronous reset, active-high
//   i_rx          serial line, idle high, asynchronous to i_clk
//   o_rx_data     last correctly framed byte (held until the next good frame)
//   o_rx_valid    one-cycle pulse: o_rx_data updated this cycle
//   o_frame_err   one-cycle pulse: stop bit sampled low
//   o_parity_err  one-cycle pulse alongside o_rx_valid on parity mismatch
//   o_busy        high while the receiver is not idle
// -----------------------------------------------------------------------------
`default_nettype none

module uart_receiver #(
  parameter int unsigned BIT_CYCLES = 160
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_busy
);

  localparam int unsigned DATA_BITS   = 8;
  localparam int unsigned HALF_CYCLES = BIT_CYCLES / 2;
  localparam int unsigned CNT_W       = $clog2(BIT_CYCLES);
  localparam int unsigned IDX_W       = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PARITY  = 3'd3,
    ST_STOP    = 3'd4,
    ST_WAIT_HI = 3'd5
  } state_t;

  // State entered after the last data bit has been shifted in.
`ifdef UART_RX_PARITY_EN
  localparam state_t ST_AFTER_DATA = ST_PARITY;
`else
  localparam state_t ST_AFTER_DATA = ST_STOP;
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic                 r_sync1;
  logic                 r_sync2;
  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_parity_err;
  logic                 r_busy;
`ifdef UART_RX_PARITY_EN
  logic                 r_parity_bit;
`endif

  // ---------------------------------------------------------------------------
  // Combinational nets
  // ---------------------------------------------------------------------------
  logic                 w_s_rx;
  logic                 w_cnt_half_end;
  logic                 w_cnt_bit_end;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_rx_valid_nxt;
  logic                 w_frame_err_nxt;
  logic                 w_parity_err_nxt;
  logic                 w_busy_nxt;
  logic                 w_parity_mismatch;
`ifdef UART_RX_PARITY_EN
  logic                 w_parity_bit_nxt;
`endif

  // Two-flop synchronizer; resets to the idle (high) line level so that
  // releasing reset never looks like a start edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s_rx         = r_sync2;
  assign w_cnt_half_end = (r_cnt == CNT_HALF_END);
  assign w_cnt_bit_end  = (r_cnt == CNT_BIT_END);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_s_rx) w_state_nxt = ST_START;
      end
      // Half a bit after the falling edge: still low means a real start bit,
      // high means a glitch and we silently go back to idle.
      ST_START: begin
        if (w_cnt_half_end) w_state_nxt = w_s_rx ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (w_cnt_bit_end && (r_bit_idx == IDX_LAST)) w_state_nxt = ST_AFTER_DATA;
      end
      ST_PARITY: begin
        if (w_cnt_bit_end) w_state_nxt = ST_STOP;
      end
      // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
      ST_STOP: begin
        if (w_cnt_bit_end) w_state_nxt = w_s_rx ? ST_IDLE : ST_WAIT_HI;
      end
      // Break / stuck-low line: wait for it to return high before rearming.
      ST_WAIT_HI: begin
        if (w_s_rx) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (values registered below)
  // ---------------------------------------------------------------------------
`ifdef UART_RX_PARITY_EN
  assign w_parity_mismatch = (^r_shift) ^ r_parity_bit;
`else
  assign w_parity_mismatch = 1'b0;
`endif

  always_comb begin
    w_rx_valid_nxt   = 1'b0;
    w_frame_err_nxt  = 1'b0;
    w_parity_err_nxt = 1'b0;
    w_busy_nxt       = (w_state_nxt != ST_IDLE);
    if ((r_state == ST_STOP) && w_cnt_bit_end) begin
      if (w_s_rx) begin
        w_rx_valid_nxt   = 1'b1;
        w_parity_err_nxt = w_parity_mismatch;
      end else begin
        w_frame_err_nxt  = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: bit-period counter, bit index and shift register
  // ---------------------------------------------------------------------------
  always_comb begin
    w_cnt_nxt   = '0;
    w_idx_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    case (r_state)
      ST_START: begin
        if (!w_cnt_half_end) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
          w_idx_nxt = '0;
        end
      end
      ST_DATA: begin
        if (!w_cnt_bit_end) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
          // LSB arrives first, so shift in from the top.
          w_shift_nxt = {w_s_rx, r_shift[DATA_BITS-1:1]};
          w_idx_nxt   = (r_bit_idx == IDX_LAST) ? '0 : r_bit_idx + IDX_W'(1);
        end
      end
      ST_PARITY, ST_STOP: begin
        if (!w_cnt_bit_end) w_cnt_nxt = r_cnt + CNT_W'(1);
      end
      default: begin
        w_cnt_nxt = '0;
      end
    endcase
  end

`ifdef UART_RX_PARITY_EN
  assign w_parity_bit_nxt = ((r_state == ST_PARITY) && w_cnt_bit_end) ? w_s_rx : r_parity_bit;
`endif

  // Datapath and output registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_bit_idx    <= w_idx_nxt;
      r_shift      <= w_shift_nxt;
      r_rx_valid   <= w_rx_valid_nxt;
      r_frame_err  <= w_frame_err_nxt;
      r_parity_err <= w_parity_err_nxt;
      r_busy       <= w_busy_nxt;
      if (w_rx_valid_nxt) r_rx_data <= r_shift;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_parity_bit <= 1'b0;
    end else begin
      r_parity_bit <= w_parity_bit_nxt;
    end
  end
`endif

  assign o_rx_data    = r_rx_data;
  assign o_rx_valid   = r_rx_valid;
  assign o_frame_err  = r_frame_err;
  assign o_parity_err = r_parity_err;
  assign o_busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
//   Drives serial frames into uart_receiver (BIT_CYCLES=16) and checks every
//   cycle against a frame-level model: each frame sent schedules the cycle at
//   which its rx_valid / frame_err pulse must appear and the window in which
//   busy must be high. Hand-computed literals pin the model at key points.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

  localparam int B = 16;
  localparam int H = B / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  // Cycles on the wire per frame, and start-edge-to-pulse distance.
  localparam int FB  = (PAR ? 11 : 10) * B;
  localparam int LAT = 3 + H + 9 * B + (PAR ? B : 0);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  uart_receiver #(.BIT_CYCLES(B)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_rx        (rx),
    .o_rx_data   (rx_data),
    .o_rx_valid  (rx_valid),
    .o_frame_err (frame_err),
    .o_parity_err(parity_err),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    bit         ferr;
    bit         perr;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    int lo;
    int hi;
  } win_t;

  ev_t        evq[$];
  win_t       busyq[$];
  logic [7:0] exp_data = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  int         valid_cnt = 0;
  int         ferr_cnt  = 0;
  int         perr_cnt  = 0;
  logic [7:0] obs_data[$];
  int         obs_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  // --- model: schedule expectations for a frame whose start edge is at n ----
  task automatic add_busy(input int lo, input int hi);
    win_t w;
    w.lo = lo;
    w.hi = hi;
    busyq.push_back(w);
  endtask

  task automatic expect_good(input int n, input logic [7:0] d, input logic pbit);
    ev_t e;
    e.at   = n + LAT;
    e.ferr = 1'b0;
    e.perr = PAR && (pbit != ^d);
    e.data = d;
    evq.push_back(e);
    add_busy(n + 3, n + LAT - 1);
  endtask

  // Stop bit low; line returns high at cycle rise.
  task automatic expect_frame_err(input int n, input int rise);
    ev_t e;
    e.at   = n + LAT;
    e.ferr = 1'b1;
    e.perr = 1'b0;
    e.data = 8'h00;
    evq.push_back(e);
    add_busy(n + 3, rise + 2);
  endtask

  function automatic logic [7:0] obs_d(input int i);
    if (i < obs_data.size()) return obs_data[i];
    return 8'hxx;
  endfunction

  function automatic int obs_c(input int i);
    if (i < obs_cyc.size()) return obs_cyc[i];
    return -1;
  endfunction

  // --- per-cycle compare ----------------------------------------------------
  task automatic check_cycle();
    ev_t  e;
    logic ev_v;
    logic ev_f;
    logic ev_p;
    logic eb;
    ev_v = 1'b0;
    ev_f = 1'b0;
    ev_p = 1'b0;
    eb   = 1'b0;
    if (rst) begin
      exp_data = 8'h00;
      evq.delete();
    end else begin
      if (evq.size() > 0 && evq[0].at == cyc) begin
        e = evq.pop_front();
        if (e.ferr) begin
          ev_f = 1'b1;
        end else begin
          ev_v     = 1'b1;
          ev_p     = e.perr;
          exp_data = e.data;
        end
      end
      foreach (busyq[i]) if (cyc >= busyq[i].lo && cyc <= busyq[i].hi) eb = 1'b1;
    end
    chk("rx_valid",   32'(rx_valid),   32'(ev_v));
    chk("frame_err",  32'(frame_err),  32'(ev_f));
    chk("parity_err", 32'(parity_err), 32'(ev_p));
    chk("busy",       32'(busy),       32'(eb));
    chk("rx_data",    32'(rx_data),    32'(exp_data));
    if (rx_valid === 1'b1) begin
      valid_cnt++;
      obs_data.push_back(rx_data);
      obs_cyc.push_back(cyc);
    end
    if (frame_err === 1'b1) ferr_cnt++;
    if (parity_err === 1'b1) perr_cnt++;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      check_cycle();
    end
  end

  // --- stimulus -------------------------------------------------------------
  // Call right after a negedge; the start bit goes low immediately.
  task automatic drive_frame(input logic [7:0] d, input logic pbit, input logic stop);
    rx = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (B) @(negedge clk);
    end
    if (PAR) begin
      rx = pbit;
      repeat (B) @(negedge clk);
    end
    rx = stop;
    repeat (B) @(negedge clk);
  endtask

  int n0;
  int n1;
  int rr;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset rx_data", 32'(rx_data), 32'h00);
    chk("reset busy",    32'(busy),    32'h0);

    // 1: single 0x55 frame
    n0 = cyc;
    expect_good(n0, 8'h55, ^8'h55);
    drive_frame(8'h55, ^8'h55, 1'b1);
    repeat (20) @(negedge clk);
    chk("t1 valid count", 32'(valid_cnt), 32'd1);
    chk("t1 rx_data",     32'(rx_data),   32'h55);
    chk("t1 latency",     32'(obs_c(0) - n0), 32'(PAR ? 171 : 155));

    // 2: 4-cycle low glitch is rejected
    n0 = cyc;
    add_busy(n0 + 3, n0 + 2 + H);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    chk("t2 valid count", 32'(valid_cnt), 32'd1);
    chk("t2 ferr count",  32'(ferr_cnt),  32'd0);

    // 3: 0xA3 with low stop bit, line then held low for 40 cycles
    n0 = cyc;
    expect_frame_err(n0, n0 + FB + 40);
    drive_frame(8'hA3, ^8'hA3, 1'b0);
    repeat (40) @(negedge clk);
    chk("t3 ferr count held", 32'(ferr_cnt), 32'd1);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("t3 ferr count",  32'(ferr_cnt),  32'd1);
    chk("t3 valid count", 32'(valid_cnt), 32'd1);
    chk("t3 rx_data",     32'(rx_data),   32'h55);

    // 4: back-to-back 0xA3, 0x0F
    n0 = cyc;
    expect_good(n0, 8'hA3, ^8'hA3);
    expect_good(n0 + FB, 8'h0F, ^8'h0F);
    drive_frame(8'hA3, ^8'hA3, 1'b1);
    drive_frame(8'h0F, ^8'h0F, 1'b1);
    repeat (20) @(negedge clk);
    chk("t4 valid count", 32'(valid_cnt), 32'd3);
    chk("t4 first byte",  32'(obs_d(1)),  32'hA3);
    chk("t4 second byte", 32'(obs_d(2)),  32'h0F);
    chk("t4 spacing",     32'(obs_c(2) - obs_c(1)), 32'(PAR ? 176 : 160));

    // 5: reset during bit 3 of 0xFF, then 0x3C
    n0 = cyc;
    rr = n0 + 4 * B + H;
    add_busy(n0 + 3, rr);
    rx = 1'b0;
    repeat (B) @(negedge clk);
    rx = 1'b1;
    repeat (3 * B + H) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5 rx_data after reset", 32'(rx_data), 32'h00);
    chk("t5 busy after reset",    32'(busy),    32'h0);
    n1 = cyc;
    expect_good(n1, 8'h3C, ^8'h3C);
    drive_frame(8'h3C, ^8'h3C, 1'b1);
    repeat (20) @(negedge clk);
    chk("t5 valid count", 32'(valid_cnt), 32'd4);
    chk("t5 rx_data",     32'(rx_data),   32'h3C);

`ifdef UART_RX_PARITY_EN
    // 6: 0x07 with wrong then correct even-parity bit
    n0 = cyc;
    expect_good(n0, 8'h07, 1'b0);
    drive_frame(8'h07, 1'b0, 1'b1);
    n1 = cyc;
    expect_good(n1, 8'h07, 1'b1);
    drive_frame(8'h07, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    chk("t6 valid count",  32'(valid_cnt), 32'd6);
    chk("t6 parity count", 32'(perr_cnt),  32'd1);
`endif

    chk("pending events", 32'(evq.size()), 32'd0);
    chk("parity pulses",  32'(perr_cnt),   32'(PAR ? 1 : 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
